vga_csr_line_fetch: RTL and testbench

- Read-side initiator on the CSR slave port of the VGA memory arbiter.
- Fetches a run of consecutive 16-bit words from video SRAM into an internal FIFO and presents them to the pixel pipeline on a valid/ready stream.
- Issues CSR reads on the fixed-latency CSR read path.
- Tracks in-flight reads so the FIFO can never overflow.

---
 rtl/vga_fetch_pkg.sv | 22 ++
 rtl/vga_csr_line_fetch_if.sv | 23 ++
 rtl/vga_sync_fifo.sv | 53 +++++
 rtl/vga_csr_line_fetch.sv | 133 +++++++++++++
 tb/tb_vga_csr_line_fetch.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_fetch_pkg.sv
// Shared types and widths for the VGA CSR line fetcher and its FIFO.
// Pointer width is derived from the FIFO depth so both files size alike.
package vga_fetch_pkg;

  localparam int ADR_W     = 17;
  localparam int DAT_W     = 16;
  localparam int DEF_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } fetch_state_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int PTR_W = ptr_w(DEF_DEPTH);

endpackage

// File: rtl/vga_csr_line_fetch_if.sv
// CSR read path plus pixel stream bundle between the line fetcher (master)
// and the arbiter / pixel pipeline side (slave).
interface vga_csr_line_fetch_if;
  import vga_fetch_pkg::*;

  logic [ADR_W-1:0] csr_adr_o;
  logic             csr_stb_o;
  logic [DAT_W-1:0] csr_dat_i;
  logic [DAT_W-1:0] pix_dat_o;
  logic             pix_valid_o;
  logic             pix_ready_i;

  modport master (
    output csr_adr_o, csr_stb_o, pix_dat_o, pix_valid_o,
    input  csr_dat_i, pix_ready_i
  );

  modport slave (
    input  csr_adr_o, csr_stb_o, pix_dat_o, pix_valid_o,
    output csr_dat_i, pix_ready_i
  );

endinterface

// File: rtl/vga_sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush; the head word reads
// as zero while empty so the pixel output is clean after reset or flush.
module vga_sync_fifo
  import vga_fetch_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [DAT_W-1:0] wr_dat,
  input  logic             pop,
  output logic [DAT_W-1:0] rd_dat,
  output logic             not_empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [DAT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign not_empty = (count != '0);
  assign do_pop    = pop && not_empty;
  assign do_push   = push && ((count != FULL) || do_pop);
  assign rd_dat    = not_empty ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/vga_csr_line_fetch.sv
// Fetches a run of consecutive words over the fixed-latency CSR read path
// into a FIFO, issuing only while FIFO words plus reads in flight fit.
//
//   state  | meaning
//   IDLE   | waiting for start_i; FIFO may still be draining to the consumer
//   FETCH  | issuing one strobe per cycle while words remain and credit allows
//   DRAIN  | no issue; waiting for in-flight reads (discarded if aborted)
//   FINISH | done_o pulse, back to IDLE
module vga_csr_line_fetch
  import vga_fetch_pkg::*;
#(
  parameter int READ_LAT = 2,
  parameter int DEPTH    = 16,
  parameter int CNT_W    = 10
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 start_i,
  input  logic [ADR_W-1:0]     base_adr_i,
  input  logic [CNT_W-1:0]     count_i,
  input  logic                 abort_i,
  vga_csr_line_fetch_if.master bus,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int AW = ptr_w(DEPTH);
  localparam int OW = AW + 2;
  localparam logic [READ_LAT-1:0] TAIL_BIT = READ_LAT'(1) << (READ_LAT - 1);

  fetch_state_t     state;
  logic [ADR_W-1:0] cur_adr;
  logic [CNT_W-1:0] remaining;
  logic [READ_LAT-1:0] pipe;
  logic             aborting;
  logic [AW:0]      fifo_count;
  logic [OW-1:0]    inflight;
  logic [OW-1:0]    occupancy;
  logic             issue;
  logic             abort_hit;
  logic             fifo_push;
  logic             last_inflight;

  // The strobe on the bus this cycle is already committed, so it counts as in flight.
  always_comb begin
    inflight = OW'(bus.csr_stb_o);
    for (int i = 0; i < READ_LAT; i++) inflight = inflight + OW'(pipe[i]);
  end

  assign occupancy     = OW'(fifo_count) + inflight;
  assign abort_hit     = abort_i && (state == FETCH || state == DRAIN);
  assign issue         = (state == FETCH) && !abort_i && (remaining != '0) &&
                         (occupancy < OW'(DEPTH));
  // True when at most the returning tail word is outstanding.
  assign last_inflight = !bus.csr_stb_o && ((pipe & ~TAIL_BIT) == '0);
  assign fifo_push     = pipe[READ_LAT-1] && !aborting && !abort_hit;

  vga_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .flush     (abort_hit),
    .push      (fifo_push),
    .wr_dat    (bus.csr_dat_i),
    .pop       (bus.pix_ready_i),
    .rd_dat    (bus.pix_dat_o),
    .not_empty (bus.pix_valid_o),
    .count     (fifo_count)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state         <= IDLE;
      cur_adr       <= '0;
      remaining     <= '0;
      pipe          <= '0;
      aborting      <= 1'b0;
      bus.csr_stb_o <= 1'b0;
      bus.csr_adr_o <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      pipe          <= READ_LAT'({pipe, bus.csr_stb_o});
      bus.csr_stb_o <= 1'b0;
      done_o        <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            cur_adr   <= base_adr_i;
            remaining <= count_i;
            aborting  <= 1'b0;
            busy_o    <= 1'b1;
            if (count_i == '0) begin
              state  <= FINISH;
              done_o <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        FETCH: begin
          if (abort_i) begin
            state    <= DRAIN;
            aborting <= 1'b1;
          end else if (issue) begin
            bus.csr_stb_o <= 1'b1;
            bus.csr_adr_o <= cur_adr;
            cur_adr       <= cur_adr + 1'b1;
            remaining     <= remaining - 1'b1;
            if (remaining == CNT_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (abort_i) aborting <= 1'b1;
          if (last_inflight) begin
            if (aborting || abort_i) begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end else begin
              state  <= FINISH;
              done_o <= 1'b1;
            end
          end
        end
        FINISH: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_csr_line_fetch.sv
// Randomized bench for vga_csr_line_fetch: a hashed SRAM model answers reads
// after READ_LAT cycles and the expected stream is mem[base + i] for i < count.
module tb_vga_csr_line_fetch;
  import vga_fetch_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = 10;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [ADR_W-1:0] base_adr = '0;
  logic [CNT_W-1:0] count = '0;
  logic busy, done;

  logic rst3 = 1'b1, start3 = 1'b0;
  logic [ADR_W-1:0] base3 = '0;
  logic [CNT_W-1:0] count3 = '0;
  logic busy3, done3;

  logic [15:0] salt = 16'h0;

  always #5 clk = ~clk;

  vga_csr_line_fetch_if bus();
  vga_csr_line_fetch_if bus3();

  vga_csr_line_fetch #(.READ_LAT(2), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .base_adr_i(base_adr),
    .count_i(count), .abort_i(abort), .bus(bus), .busy_o(busy), .done_o(done));

  vga_csr_line_fetch #(.READ_LAT(3), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut3 (
    .wb_clk_i(clk), .wb_rst_i(rst3), .start_i(start3), .base_adr_i(base3),
    .count_i(count3), .abort_i(1'b0), .bus(bus3), .busy_o(busy3), .done_o(done3));

  int n_chk = 0, n_fail = 0;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [16:0] a);
    logic [31:0] h;
    h = {15'd0, a} * 32'h9E3779B1;
    return h[31:16] ^ salt;
  endfunction

  // reference state, written by the stimulus side
  logic [16:0] exp_base = '0;
  int exp_cnt = 0, ready_mode = 1, epoch = 0;
  int stb0 = 0, pop0 = 0, done0 = 0;
  // observations, written by the monitor
  int cyc = 0, n_stb = 0, n_pop = 0, n_done = 0;
  int stb_ep = -1, val_ep = -1;
  int first_stb_cyc = 0, last_stb_cyc = 0, first_val_cyc = 0;
  int first_pop_cyc = 0, last_pop_cyc = 0, done_cyc = 0, busy_fall_cyc = 0;
  logic busy_prev = 1'b0;
  logic [17:0] rq[$];
  logic [17:0] rq3[$];

  always @(negedge clk) begin : mon
    logic [17:0] r;
    cyc++;
    rq.push_back({bus.csr_stb_o, bus.csr_adr_o});
    if (rq.size() > 2) begin
      r = rq.pop_front();
      bus.csr_dat_i = r[17] ? mem_word(r[16:0]) : 16'($urandom);
    end else begin
      bus.csr_dat_i = 16'($urandom);
    end
    if (bus.csr_stb_o) begin
      if (stb_ep != epoch) begin first_stb_cyc = cyc; stb_ep = epoch; end
      last_stb_cyc = cyc;
      chk_val("stb_adr", 32'(bus.csr_adr_o), 32'(17'(exp_base + 17'(n_stb - stb0))));
      n_stb++;
      chk_val("credit", 32'(((n_stb - stb0) - (n_pop - pop0)) <= DEPTH), 32'd1);
    end
    if (bus.pix_valid_o && val_ep != epoch) begin first_val_cyc = cyc; val_ep = epoch; end
    case (ready_mode)
      0:       bus.pix_ready_i = 1'b0;
      1:       bus.pix_ready_i = 1'b1;
      default: bus.pix_ready_i = 1'($urandom % 2);
    endcase
    if (bus.pix_valid_o && bus.pix_ready_i) begin
      if (n_pop - pop0 < exp_cnt)
        chk_val("pix_dat", 32'(bus.pix_dat_o), 32'(mem_word(17'(exp_base + 17'(n_pop - pop0)))));
      else
        chk_val("pix_extra", 32'(n_pop - pop0 + 1), 32'(exp_cnt));
      if (n_pop == pop0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
      n_pop++;
    end
    if (done) begin n_done++; done_cyc = cyc; end
    if (busy_prev && !busy) busy_fall_cyc = cyc;
    busy_prev = busy;
  end

  always @(negedge clk) begin : mon3
    logic [17:0] r;
    rq3.push_back({bus3.csr_stb_o, bus3.csr_adr_o});
    if (rq3.size() > 3) begin
      r = rq3.pop_front();
      bus3.csr_dat_i = r[17] ? mem_word(r[16:0]) : 16'($urandom);
    end else begin
      bus3.csr_dat_i = 16'($urandom);
    end
    bus3.pix_ready_i = 1'b1;
  end

  task automatic begin_fetch(input logic [16:0] b, input int c, input int mode);
    epoch++;
    exp_base = b; exp_cnt = c; ready_mode = mode;
    stb0 = n_stb; pop0 = n_pop; done0 = n_done;
    @(negedge clk);
    start = 1'b1; base_adr = b; count = CNT_W'(c);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_fetch(input string tag, input int limit);
    int t = 0;
    while ((busy || (n_pop - pop0) < exp_cnt) && t < limit) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk_val({tag, "_timeout"}, 32'(t < limit), 32'd1);
    chk_val({tag, "_stb_cnt"}, 32'(n_stb - stb0), 32'(exp_cnt));
    chk_val({tag, "_pop_cnt"}, 32'(n_pop - pop0), 32'(exp_cnt));
    chk_val({tag, "_done_cnt"}, 32'(n_done - done0), 32'd1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k, t, leak;
    salt = 16'($urandom);
    repeat (3) @(negedge clk);
    chk_val("rst_stb", 32'(bus.csr_stb_o), 32'd0);
    chk_val("rst_adr", 32'(bus.csr_adr_o), 32'd0);
    chk_val("rst_valid", 32'(bus.pix_valid_o), 32'd0);
    chk_val("rst_dat", 32'(bus.pix_dat_o), 32'd0);
    chk_val("rst_busy", 32'(busy), 32'd0);
    chk_val("rst_done", 32'(done), 32'd0);
    rst = 1'b0; rst3 = 1'b0;
    @(negedge clk);

    // basic run, latency and throughput
    begin_fetch(17'h00100, 4, 1);
    finish_fetch("t1", 200);
    chk_val("t1_stb_span", 32'(last_stb_cyc - first_stb_cyc), 32'd3);
    chk_val("t1_first_latency", 32'(first_val_cyc - first_stb_cyc), 32'd3);
    chk_val("t1_pop_span", 32'(last_pop_cyc - first_pop_cyc), 32'd3);
    chk_val("t1_busy_fall", 32'(busy_fall_cyc - done_cyc), 32'd1);

    // backpressure: credit stalls at DEPTH
    begin_fetch(17'h02000, 40, 0);
    repeat (40) @(negedge clk);
    chk_val("t2_stall_stb", 32'(n_stb - stb0), 32'd16);
    chk_val("t2_stall_idle_bus", 32'(bus.csr_stb_o), 32'd0);
    chk_val("t2_full_valid", 32'(bus.pix_valid_o), 32'd1);
    ready_mode = 1;
    finish_fetch("t2", 500);

    // address wrap
    begin_fetch(17'h1FFFE, 4, 1);
    finish_fetch("t3", 200);

    // zero-length fetch
    begin_fetch(17'h00500, 0, 1);
    chk_val("t4_done", 32'(done), 32'd1);
    chk_val("t4_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk_val("t4_done_end", 32'(done), 32'd0);
    chk_val("t4_busy_end", 32'(busy), 32'd0);
    chk_val("t4_stb_cnt", 32'(n_stb - stb0), 32'd0);

    // abort on the third strobe
    begin_fetch(17'h00A00, 10, 1);
    exp_cnt = 0;
    k = 0;
    t = 0;
    while (t < 100) begin
      if (bus.csr_stb_o) k++;
      if (k == 3) break;
      @(negedge clk);
      t++;
    end
    chk_val("t5_reach_third", 32'(k), 32'd3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (2) @(negedge clk);
    chk_val("t5_idle", 32'(busy), 32'd0);
    repeat (6) @(negedge clk);
    chk_val("t5_stb_cnt", 32'(n_stb - stb0), 32'd3);
    chk_val("t5_valid", 32'(bus.pix_valid_o), 32'd0);
    chk_val("t5_no_done", 32'(n_done - done0), 32'd0);
    begin_fetch(17'h00C40, 5, 1);
    finish_fetch("t5_restart", 200);

    // randomized runs with random backpressure
    for (int i = 0; i < 8; i++) begin
      begin_fetch(17'($urandom), int'($urandom_range(1, 48)), 2);
      finish_fetch("rnd", 2000);
    end

    // reset mid-fetch on the READ_LAT=3 instance
    @(negedge clk);
    start3 = 1'b1; base3 = 17'($urandom); count3 = 10'd20;
    @(negedge clk);
    start3 = 1'b0;
    k = 0;
    t = 0;
    while (t < 100) begin
      if (bus3.csr_stb_o) k++;
      if (k == 4) break;
      @(negedge clk);
      t++;
    end
    chk_val("t6_reach_fourth", 32'(k), 32'd4);
    rst3 = 1'b1;
    @(negedge clk);
    chk_val("t6_stb", 32'(bus3.csr_stb_o), 32'd0);
    chk_val("t6_adr", 32'(bus3.csr_adr_o), 32'd0);
    chk_val("t6_valid", 32'(bus3.pix_valid_o), 32'd0);
    chk_val("t6_dat", 32'(bus3.pix_dat_o), 32'd0);
    chk_val("t6_busy", 32'(busy3), 32'd0);
    chk_val("t6_done", 32'(done3), 32'd0);
    rst3 = 1'b0;
    leak = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus3.pix_valid_o || bus3.csr_stb_o) leak++;
    end
    chk_val("t6_late_data", 32'(leak), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
